// File: rtl/sd_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : sd_init_seq
// Purpose  : SD card initialisation sequencer. Drives the SD command engine
//            through CMD0, CMD8, CMD55/ACMD41 polling, CMD2, CMD3, CMD7 and
//            (byte-addressed cards only) CMD16. It classifies the card,
//            captures the RCA and switches the engine clock divider to the
//            transfer rate on success.
// Ports    : clk, rstn (async, active-low)
//            init_req            - one-cycle (re)initialise request
//            init_busy/ready/error/err_code - sequence status
//            card_type, rca      - identification results
//            sd_clkdiv, sd_start, sd_precnt, sd_cmd, sd_arg - to engine
//            sd_busy, sd_done, sd_timeout, sd_syntaxe, sd_resparg - from engine
// Revision : 1.0 - initial release
// ============================================================================
module sd_init_seq #(
  parameter logic [15:0] SLOW_DIV     = 16'd99,
  parameter logic [15:0] FAST_DIV     = 16'd1,
  parameter logic [15:0] ACMD41_TRIES = 16'd1000,
  parameter logic [2:0]  CMD_RETRIES  = 3'd3,
  parameter logic [15:0] PRE_LONG     = 16'd160,
  parameter logic [15:0] PRE_SHORT    = 16'd8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        init_req,
  output logic        init_busy,
  output logic        ready,
  output logic        error,
  output logic [3:0]  err_code,
  output logic [1:0]  card_type,
  output logic [15:0] rca,
  output logic [15:0] sd_clkdiv,
  output logic        sd_start,
  output logic [15:0] sd_precnt,
  output logic [5:0]  sd_cmd,
  output logic [31:0] sd_arg,
  input  logic        sd_busy,
  input  logic        sd_done,
  input  logic        sd_timeout,
  input  logic        sd_syntaxe,
  input  logic [31:0] sd_resparg
);

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE, ST_ERROR} state_t;
  typedef enum logic [2:0] {SP_CMD0, SP_CMD8, SP_CMD55, SP_ACMD41,
                            SP_CMD2, SP_CMD3, SP_CMD7, SP_CMD16} step_t;
  typedef enum logic [1:0] {AC_ISSUE, AC_DONE, AC_ERROR} act_t;

  state_t      r_state;
  step_t       r_step;
  logic [2:0]  r_retry;
  logic [15:0] r_acnt;
  logic        r_v2;

  // Outcome of the current WAIT step, evaluated combinationally from the
  // response inputs and applied in the cycle sd_done is high.
  act_t        w_act;
  step_t       w_nstep;
  logic        w_retry;
  logic [3:0]  w_err;
  logic [1:0]  w_ntype;
  logic        w_nv2;
  logic [15:0] w_nrca;
  logic [15:0] w_nacnt;
  logic        w_unused;

  assign w_unused = ^sd_resparg[15:12];

  function automatic logic [5:0] f_cmd(input step_t s);
    case (s)
      SP_CMD0:   f_cmd = 6'd0;
      SP_CMD8:   f_cmd = 6'd8;
      SP_CMD55:  f_cmd = 6'd55;
      SP_ACMD41: f_cmd = 6'd41;
      SP_CMD2:   f_cmd = 6'd2;
      SP_CMD3:   f_cmd = 6'd3;
      SP_CMD7:   f_cmd = 6'd7;
      default:   f_cmd = 6'd16;
    endcase
  endfunction

  function automatic logic [31:0] f_arg(input step_t s, input logic v2, input logic [15:0] r);
    case (s)
      SP_CMD8:   f_arg = 32'h0000_01AA;
      SP_ACMD41: f_arg = v2 ? 32'h4010_0000 : 32'h0010_0000;
      SP_CMD7:   f_arg = {r, 16'h0000};
      SP_CMD16:  f_arg = 32'd512;
      default:   f_arg = 32'd0;
    endcase
  endfunction

  // CMD0 needs the long power-up idle; CMD3 follows CMD2 and gets it too.
  function automatic logic [15:0] f_pre(input step_t s);
    f_pre = (s == SP_CMD0 || s == SP_CMD3) ? PRE_LONG : PRE_SHORT;
  endfunction

  function automatic logic [3:0] f_err(input step_t s);
    case (s)
      SP_CMD8:   f_err = 4'd2;
      SP_ACMD41: f_err = 4'd3;
      SP_CMD2:   f_err = 4'd4;
      SP_CMD3:   f_err = 4'd5;
      SP_CMD7:   f_err = 4'd6;
      SP_CMD16:  f_err = 4'd7;
      SP_CMD55:  f_err = 4'd8;
      default:   f_err = 4'd1;
    endcase
  endfunction

  always_comb begin
    w_act   = AC_ISSUE;
    w_nstep = r_step;
    w_retry = 1'b0;
    w_err   = 4'd0;
    w_ntype = card_type;
    w_nv2   = r_v2;
    w_nrca  = rca;
    w_nacnt = r_acnt;
    if (r_step == SP_CMD0) begin
      // The card gives no response to CMD0, so any completion moves on.
      w_nstep = SP_CMD8;
    end else if (r_step == SP_CMD8) begin
      if (sd_timeout) begin
        // No answer to CMD8 identifies a v1 card rather than a failure.
        w_nv2   = 1'b0;
        w_nstep = SP_CMD55;
      end else if (sd_syntaxe || sd_resparg[11:0] != 12'h1AA) begin
        w_act = AC_ERROR;
        w_err = 4'd2;
      end else begin
        w_nv2   = 1'b1;
        w_nstep = SP_CMD55;
      end
    end else if (sd_timeout) begin
      if (r_retry != 3'd0) begin
        w_retry = 1'b1;
      end else begin
        w_act = AC_ERROR;
        w_err = f_err(r_step);
      end
    end else if (sd_syntaxe) begin
      w_act = AC_ERROR;
      w_err = f_err(r_step);
    end else begin
      case (r_step)
        SP_CMD55: w_nstep = SP_ACMD41;
        SP_ACMD41: begin
          if (sd_resparg[31]) begin
            w_ntype = r_v2 ? (sd_resparg[30] ? 2'd3 : 2'd2) : 2'd1;
            w_nstep = SP_CMD2;
          end else begin
            w_nacnt = r_acnt - 16'd1;
            if (r_acnt <= 16'd1) begin
              w_act = AC_ERROR;
              w_err = 4'd3;
            end else begin
              w_nstep = SP_CMD55;
            end
          end
        end
        SP_CMD2: w_nstep = SP_CMD3;
        SP_CMD3: begin
          w_nrca  = sd_resparg[31:16];
          w_nstep = SP_CMD7;
        end
        SP_CMD7: begin
          // Block-addressed cards have a fixed 512-byte block; skip CMD16.
          if (card_type == 2'd3) w_act = AC_DONE;
          else                   w_nstep = SP_CMD16;
        end
        default: w_act = AC_DONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_step    <= SP_CMD0;
      r_retry   <= 3'd0;
      r_acnt    <= 16'd0;
      r_v2      <= 1'b0;
      init_busy <= 1'b0;
      ready     <= 1'b0;
      error     <= 1'b0;
      err_code  <= 4'd0;
      card_type <= 2'd0;
      rca       <= 16'd0;
      sd_clkdiv <= SLOW_DIV;
      sd_start  <= 1'b0;
      sd_precnt <= 16'd0;
      sd_cmd    <= 6'd0;
      sd_arg    <= 32'd0;
    end else begin
      sd_start <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (init_req) begin
            ready     <= 1'b0;
            error     <= 1'b0;
            err_code  <= 4'd0;
            card_type <= 2'd0;
            rca       <= 16'd0;
            sd_clkdiv <= SLOW_DIV;
            init_busy <= 1'b1;
            r_acnt    <= ACMD41_TRIES;
            r_retry   <= CMD_RETRIES;
            r_v2      <= 1'b0;
            r_step    <= SP_CMD0;
            sd_cmd    <= f_cmd(SP_CMD0);
            sd_arg    <= f_arg(SP_CMD0, 1'b0, 16'd0);
            sd_precnt <= f_pre(SP_CMD0);
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!sd_busy) begin
            sd_start <= 1'b1;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sd_done) begin
            card_type <= w_ntype;
            r_v2      <= w_nv2;
            rca       <= w_nrca;
            r_acnt    <= w_nacnt;
            case (w_act)
              AC_ISSUE: begin
                r_step    <= w_nstep;
                sd_cmd    <= f_cmd(w_nstep);
                sd_arg    <= f_arg(w_nstep, w_nv2, w_nrca);
                sd_precnt <= f_pre(w_nstep);
                r_retry   <= w_retry ? (r_retry - 3'd1) : CMD_RETRIES;
                r_state   <= ST_ISSUE;
              end
              AC_DONE: begin
                sd_clkdiv <= FAST_DIV;
                init_busy <= 1'b0;
                ready     <= 1'b1;
                r_state   <= ST_DONE;
              end
              default: begin
                init_busy <= 1'b0;
                error     <= 1'b1;
                err_code  <= w_err;
                card_type <= 2'd0;
                r_state   <= ST_ERROR;
              end
            endcase
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sd_init_seq.md
# sd_init_seq

Card-initialisation sequencer that sits directly above the SD command engine in the SD data path. On request it drives the engine through the SD power-up sequence: CMD0, CMD8, CMD55/ACMD41 polling, CMD2, CMD3, CMD7, and CMD16 for non-SDHC cards only. It classifies the card, captures the RCA, and switches the engine clock divider from the identification rate to the transfer rate. When it reports `ready`, the block reader may use the engine.

## Interface
- `SLOW_DIV`, default 16'd99: divider during identification; sdclk period = 2*(div+1) clk.
- `FAST_DIV`, default 16'd1: divider applied on success.
- `ACMD41_TRIES`, default 16'd1000: maximum CMD55/ACMD41 pairs.
- `CMD_RETRIES`, default 3'd3: timeout retries per command (CMD0 excluded).
- `PRE_LONG`, default 16'd160: precnt for CMD0 and for the command following CMD2.
- `PRE_SHORT`, default 16'd8: precnt for all other commands.
- `clk`, in, 1: system clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `init_req`, in, 1: one-cycle request to (re)initialise.
- `init_busy`, out, 1: sequence in progress.
- `ready`, out, 1: card in transfer state, fast clock applied.
- `error`, out, 1: sequence aborted.
- `err_code`, out, 4: failing step (see Operation).
- `card_type`, out, 2: 0 none, 1 SDv1, 2 SDv2 byte-addressed, 3 SDHC/SDXC.
- `rca`, out, 16: relative card address from CMD3.
- `sd_clkdiv`, out, 16: divider to engine.
- `sd_start`, out, 1: command start strobe.
- `sd_precnt`, out, 16: idle sdclk cycles before command.
- `sd_cmd`, out, 6: command index.
- `sd_arg`, out, 32: command argument.
- `sd_busy`, in, 1: engine busy.
- `sd_done`, in, 1: engine done pulse.
- `sd_timeout`, in, 1: no response, valid with done.
- `sd_syntaxe`, in, 1: response framing or index error, valid with done.
- `sd_resparg`, in, 32: response argument field, valid with done.

## Operation
- **Reset values:**
  - All 1-bit outputs 0.
  - `err_code`, `card_type`, `rca`, `sd_cmd`, `sd_arg`, `sd_precnt` all 0.
  - `sd_clkdiv` = SLOW_DIV.
- **Start of sequence.** `init_req` is accepted in IDLE, DONE or ERROR and ignored otherwise. On acceptance:
  - clear `ready`, `error`, `err_code`, `card_type`, `rca`;
  - set `sd_clkdiv` to SLOW_DIV;
  - set `init_busy` = 1.
- **Each step** uses an ISSUE state followed by a WAIT state.
  - ISSUE loads `sd_cmd`, `sd_arg`, `sd_precnt`.
  - When `sd_busy` = 0 in ISSUE, pulse `sd_start` for exactly one cycle and move to WAIT.
  - `sd_cmd`, `sd_arg`, `sd_precnt` stay constant from ISSUE entry until `sd_done`.
  - WAIT evaluates `sd_done` and the response inputs in the cycle `sd_done` = 1.
- **Step evaluation.** A step passes when `done & ~timeout & ~syntaxe`, unless stated otherwise. A timeout retries the same step up to CMD_RETRIES times, then goes to ERROR. A syntax error goes to ERROR immediately.
  - **CMD0**, arg 0, precnt PRE_LONG: any `done` passes (timeout expected).
  - **CMD8**, arg 32'h1AA:
    - pass with `resparg[11:0]` = 12'h1AA → v2;
    - timeout → v1, no retry;
    - mismatch or syntax error → err 2.
  - **CMD55**, arg 0: failure → err 8.
  - **ACMD41**, arg 32'h40100000 for v2, 32'h00100000 for v1:
    - `resparg[31]` = 1 → card_type = v1 ? 1 : (`resparg[30]` ? 3 : 2), go to CMD2;
    - else decrement the try counter and return to CMD55;
    - counter reaching 0 → err 3.
  - **CMD2**, arg 0: failure → err 4.
  - **CMD3**, arg 0, precnt PRE_LONG: `rca` ← `resparg[31:16]`; failure → err 5.
  - **CMD7**, arg {rca, 16'h0}: failure → err 6.
  - **CMD16**, arg 512: skipped when card_type = 3; failure → err 7.
- **DONE:** `sd_clkdiv` ← FAST_DIV, `init_busy` = 0, `ready` = 1.
- **ERROR:** `init_busy` = 0, `error` = 1, `err_code` held, `card_type` = 0.
- **Counters:** the retry counter reloads at every new step; the ACMD41 counter reloads only at init acceptance.

## Timing
- `sd_start` is registered, high 1 cycle, and never asserted while `sd_busy` = 1.
- `sd_done` → next ISSUE entry: 1 cycle. The next `sd_start` waits for `sd_busy` to fall, which happens the cycle after done.
- `ready`/`error` rise 1 cycle after the final `sd_done`.
- `sd_clkdiv` changes only in IDLE→CMD0 and in DONE, never while `sd_busy` = 1.
- `rstn` low at any time, including mid-command: immediate return to reset values and IDLE. `sd_start` goes low asynchronously.
- `init_req` coinciding with `sd_done` in WAIT is ignored.

## Test plan
- SDHC model (CMD0 timeout, CMD8 echo 1AA, ACMD41 busy twice then 32'hC0FF8000, CMD3 resparg 32'h12340500) → card_type 3, rca 16'h1234, no CMD16 issued, `sd_clkdiv` = FAST_DIV, `ready` = 1.
- v1 card: CMD8 timeout, ACMD41 ready with resparg 32'h80FF8000 → ACMD41 arg 32'h00100000, card_type 1, CMD16 arg 512 issued.
- CMD8 echo 32'h000001AB → `error` = 1, err_code 2, no further `sd_start`.
- ACMD41 never ready with ACMD41_TRIES = 3 → exactly 3 CMD55/ACMD41 pairs, err_code 3.
- CMD7 times out 4 times → 1 issue + 3 retries, err_code 6; then `init_req` → sequence restarts at CMD0 with `sd_clkdiv` = SLOW_DIV.
- `rstn` pulsed during ACMD41 WAIT → all outputs at reset values; `init_req` pulsed while `init_busy` = 1 → ignored.
